flip_flop_bank: RTL and testbench

- Parametrised successor to the two-flip-flop lab circuit: WIDTH flip-flops that share one clock, plus a parity-style Z output.
- A 3-bit mode input selects the next-state function each cycle: hold, load, toggle-mask, shift left/right, count up/down, or clear.
- The block is the general state-holding element for later lab circuits; the earlier 2-bit Q0/Q1/Z circuit is the WIDTH=2 instance with Z = XNOR of the Q bits.

---
 rtl/flip_flop_bank.sv | 105 ++++++++++
 tb/tb_flip_flop_bank.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/flip_flop_bank.sv
// WIDTH-bit bank of flip-flops with a mode-selected next-state function, parity Z and wrap pulse.
// Optional macro FLIP_FLOP_BANK_SATURATE_EN: count up/down saturates instead of wrapping.
module flip_flop_bank #(
  parameter int WIDTH     = 2,
  parameter int RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] Q,
  output logic             Z,
  output logic             wrap
);

  typedef enum logic [2:0] {
    MODE_HOLD   = 3'b000,
    MODE_LOAD   = 3'b001,
    MODE_TOGGLE = 3'b010,
    MODE_SHL    = 3'b011,
    MODE_SHR    = 3'b100,
    MODE_UP     = 3'b101,
    MODE_DOWN   = 3'b110,
    MODE_CLEAR  = 3'b111
  } mode_t;

  localparam logic [WIDTH-1:0] RST_Q = WIDTH'(RESET_VAL);
  localparam logic [WIDTH-1:0] ZERO  = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONES  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ONE   = {{(WIDTH-1){1'b0}}, 1'b1};

  // High when the vector holds an even number of ones.
  function automatic logic even_parity(input logic [WIDTH-1:0] v);
    return ~(^v);
  endfunction

  logic [WIDTH-1:0] q_r;
  logic             wrap_r;
  logic [WIDTH-1:0] q_next_s;
  logic             wrap_next_s;

  // Next-state and wrap-detect logic; unknown modes poison Q until reset.
  always_comb begin
    q_next_s    = q_r;
    wrap_next_s = 1'b0;
    if (en) begin
      case (mode_t'(mode))
        MODE_HOLD:   q_next_s = q_r;
        MODE_LOAD:   q_next_s = din;
        MODE_TOGGLE: q_next_s = q_r ^ din;
        MODE_SHL:    q_next_s = {q_r[WIDTH-2:0], din[0]};
        MODE_SHR:    q_next_s = {din[WIDTH-1], q_r[WIDTH-1:1]};
        MODE_UP: begin
          if (q_r == ONES) begin
            wrap_next_s = 1'b1;
`ifdef FLIP_FLOP_BANK_SATURATE_EN
            q_next_s    = ONES;
`else
            q_next_s    = ZERO;
`endif
          end else begin
            q_next_s    = q_r + ONE;
          end
        end
        MODE_DOWN: begin
          if (q_r == ZERO) begin
            wrap_next_s = 1'b1;
`ifdef FLIP_FLOP_BANK_SATURATE_EN
            q_next_s    = ZERO;
`else
            q_next_s    = ONES;
`endif
          end else begin
            q_next_s    = q_r - ONE;
          end
        end
        MODE_CLEAR:  q_next_s = ZERO;
        default: begin
          q_next_s    = {WIDTH{1'bx}};
          wrap_next_s = 1'b0;
        end
      endcase
    end else begin
      q_next_s    = q_r;
      wrap_next_s = 1'b0;
    end
  end

  // State and wrap registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_r    <= RST_Q;
      wrap_r <= 1'b0;
    end else begin
      q_r    <= q_next_s;
      wrap_r <= wrap_next_s;
    end
  end

  assign Q    = q_r;
  assign wrap = wrap_r;
  assign Z    = even_parity(q_r);

endmodule

// File: tb/tb_flip_flop_bank.sv
// Self-checking bench: a WIDTH=2 and a WIDTH=4 (RESET_VAL=0101) bank share stimulus and are
// compared each edge with an arithmetic reference model, plus directed checks.
module tb_flip_flop_bank;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [2:0] mode;
  logic [3:0] din;
  logic [1:0] q2;
  logic [3:0] q4;
  logic       z2, z4, wrap2, wrap4;

  int n_cmp = 0;
  int n_err = 0;
  int mq2, mw2, mq4, mw4;

  always #5 clk = ~clk;

  flip_flop_bank #(.WIDTH(2), .RESET_VAL(0)) u_dut2 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .din(din[1:0]),
    .Q(q2), .Z(z2), .wrap(wrap2)
  );

  flip_flop_bank #(.WIDTH(4), .RESET_VAL(5)) u_dut4 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .din(din),
    .Q(q4), .Z(z4), .wrap(wrap4)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int even_ones(input int v);
    return ($countones(v) % 2 == 0) ? 1 : 0;
  endfunction

  // Reference next state from the mode rules, using plain integer arithmetic.
  task automatic model_next(input int w, input int q, input int e, input int m, input int d,
                            output int nq, output int nw);
    int top, dm;
    top = (1 << w);
    dm  = d % top;
    nq  = q;
    nw  = 0;
    if (e != 0) begin
      case (m)
        1: nq = dm;
        2: nq = q ^ dm;
        3: nq = (q * 2 + (d % 2)) % top;
        4: nq = q / 2 + ((dm / (top / 2)) % 2) * (top / 2);
        5: if (q == top - 1) begin
             nw = 1;
`ifdef FLIP_FLOP_BANK_SATURATE_EN
             nq = q;
`else
             nq = 0;
`endif
           end else nq = q + 1;
        6: if (q == 0) begin
             nw = 1;
`ifdef FLIP_FLOP_BANK_SATURATE_EN
             nq = 0;
`else
             nq = top - 1;
`endif
           end else nq = q - 1;
        7: nq = 0;
        default: nq = q;
      endcase
    end
  endtask

  task automatic compare_all();
    check_eq("q2", q2, mq2);
    check_eq("z2", z2, even_ones(mq2));
    check_eq("wrap2", wrap2, mw2);
    check_eq("q4", q4, mq4);
    check_eq("z4", z4, even_ones(mq4));
    check_eq("wrap4", wrap4, mw4);
  endtask

  // Called at a falling edge: drive, take one rising edge, update model, check.
  task automatic step(input logic e, input logic [2:0] m, input logic [3:0] d);
    int nq, nw;
    en = e; mode = m; din = d;
    @(posedge clk);
    model_next(2, mq2, int'(e), int'(m), int'(d), nq, nw); mq2 = nq; mw2 = nw;
    model_next(4, mq4, int'(e), int'(m), int'(d), nq, nw); mq4 = nq; mw4 = nw;
    #1;
    compare_all();
    @(negedge clk);
  endtask

  // Mid-cycle reset pulse: checked before any edge, released at the next falling edge.
  task automatic mid_reset();
    rst = 1'b1;
    #1;
    mq2 = 0; mw2 = 0; mq4 = 5; mw4 = 0;
    compare_all();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; mode = 3'b000; din = 4'b0000;
    mq2 = 0; mw2 = 0; mq4 = 5; mw4 = 0;
    #1;
    check_eq("rst_q2", q2, 2'b00);
    check_eq("rst_z2", z2, 1'b1);
    check_eq("rst_wrap2", wrap2, 1'b0);
    check_eq("rst_q4", q4, 4'b0101);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b1, 3'b000, 4'b1111);
    check_eq("hold_q2", q2, 2'b00);

    // Load and toggle
    step(1'b1, 3'b001, 4'b1010);
    check_eq("load_q4", q4, 4'b1010);
    check_eq("load_z4", z4, 1'b1);
    step(1'b1, 3'b010, 4'b0011);
    check_eq("tog1_q4", q4, 4'b1001);
    check_eq("tog1_z4", z4, 1'b1);
    step(1'b1, 3'b010, 4'b0011);
    check_eq("tog2_q4", q4, 4'b1010);

    // Shifts
    step(1'b1, 3'b001, 4'b1000);
    step(1'b1, 3'b011, 4'b0001);
    check_eq("shl1_q4", q4, 4'b0001);
    step(1'b1, 3'b011, 4'b0001);
    check_eq("shl2_q4", q4, 4'b0011);
    step(1'b1, 3'b100, 4'b0000);
    check_eq("shr_q4", q4, 4'b0001);

    // Counting across the wrap boundary
    step(1'b1, 3'b001, 4'b1110);
    step(1'b1, 3'b101, 4'b0000);
    check_eq("up1_q4", q4, 4'b1111);
    check_eq("up1_wrap4", wrap4, 1'b0);
    step(1'b1, 3'b101, 4'b0000);
`ifdef FLIP_FLOP_BANK_SATURATE_EN
    check_eq("up2_q4", q4, 4'b1111);
`else
    check_eq("up2_q4", q4, 4'b0000);
`endif
    check_eq("up2_wrap4", wrap4, 1'b1);
    step(1'b1, 3'b101, 4'b0000);
`ifdef FLIP_FLOP_BANK_SATURATE_EN
    check_eq("up3_q4", q4, 4'b1111);
    check_eq("up3_wrap4", wrap4, 1'b1);
`else
    check_eq("up3_q4", q4, 4'b0001);
    check_eq("up3_wrap4", wrap4, 1'b0);
`endif
    step(1'b1, 3'b001, 4'b0000);
    step(1'b1, 3'b110, 4'b0000);
`ifdef FLIP_FLOP_BANK_SATURATE_EN
    check_eq("dn_q4", q4, 4'b0000);
`else
    check_eq("dn_q4", q4, 4'b1111);
`endif
    check_eq("dn_wrap4", wrap4, 1'b1);
    step(1'b1, 3'b000, 4'b0000);
    check_eq("dn_wrap4_off", wrap4, 1'b0);

    // Enable low blocks counting and clears wrap
    step(1'b1, 3'b001, 4'b1111);
    step(1'b1, 3'b101, 4'b0000);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 3'b101, 4'b0000);
      check_eq("en0_wrap4", wrap4, 1'b0);
    end
    check_eq("en0_q4", q4, mq4);
    step(1'b1, 3'b111, 4'b1111);
    check_eq("clr_q4", q4, 4'b0000);
    check_eq("clr_z4", z4, 1'b1);

    // Reset while a wrap pulse is showing, then resume counting
    step(1'b1, 3'b001, 4'b1111);
    step(1'b1, 3'b101, 4'b0000);
    mid_reset();
    check_eq("mrst_q4", q4, 4'b0101);
    check_eq("mrst_wrap4", wrap4, 1'b0);
    step(1'b1, 3'b101, 4'b0000);
    check_eq("resume_q4", q4, 4'b0110);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 49) == 0) mid_reset();
      else step(($urandom_range(0, 7) != 0), 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
